// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply-divide unit.
// The master side issues operations; the slave side is the unit.
interface muldiv_unit_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic [2:0]        op;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic              flush;
   logic              isbusy;
   logic              done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output start, op, src_a, src_b, flush,
      input  isbusy, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, flush,
      output isbusy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: single-cycle MULT/MULTU, 32-step restoring DIV/DIVU,
// and MTHI/MTLO writes, with flush abort and architectural HI/LO registers.
module muldiv_unit #(
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_unit_if.slave  bus
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

   function automatic logic [DATA_W-1:0] f_abs(input logic signed [DATA_W-1:0] v);
      return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
   endfunction

   function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v);
      return -v;
   endfunction

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_busy;
   logic              r_done;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic              r_signed;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_divz;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_quo;
   logic [DATA_W-1:0] r_div;

   logic                       w_issue;
   logic signed [2*DATA_W-1:0] w_opa;
   logic signed [2*DATA_W-1:0] w_opb;
   logic [2*DATA_W-1:0]        w_prod;
   logic [DATA_W:0]            w_rem_sh;
   logic [DATA_W:0]            w_diff;
   logic                       w_borrow;
   logic [DATA_W-1:0]          w_rem_nxt;
   logic [DATA_W-1:0]          w_quo_nxt;
   logic [DATA_W-1:0]          w_q_fix;
   logic [DATA_W-1:0]          w_r_fix;

   // Multiply/divide issue only; MTHI/MTLO never leave IDLE.
   assign w_issue = (r_state == S_IDLE) && bus.start && !bus.flush && !bus.op[2];

   // Sign- or zero-extend to full product width so one multiplier serves both forms.
   assign w_opa  = r_signed ? {{DATA_W{r_a[DATA_W-1]}}, r_a} : {{DATA_W{1'b0}}, r_a};
   assign w_opb  = r_signed ? {{DATA_W{r_b[DATA_W-1]}}, r_b} : {{DATA_W{1'b0}}, r_b};
   assign w_prod = w_opa * w_opb;

   assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
   assign w_diff    = w_rem_sh - {1'b0, r_div};
   assign w_borrow  = w_diff[DATA_W];
   assign w_rem_nxt = w_borrow ? w_rem_sh[DATA_W-1:0] : w_diff[DATA_W-1:0];
   assign w_quo_nxt = {r_quo[DATA_W-2:0], ~w_borrow};

   // A zero divisor bypasses sign correction and returns the raw dividend in HI.
   assign w_q_fix = r_divz  ? {DATA_W{1'b1}} : (r_neg_q ? f_neg(r_quo) : r_quo);
   assign w_r_fix = r_divz  ? r_a            : (r_neg_r ? f_neg(r_rem) : r_rem);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         if (bus.flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start) begin
                     case (bus.op)
                        OP_MULT, OP_MULTU: begin
                           r_state <= S_MUL;
                           r_busy  <= 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                           r_state <= S_DIV;
                           r_busy  <= 1'b1;
                           r_cnt   <= '0;
                        end
                        OP_MTHI: r_hi <= bus.src_a;
                        OP_MTLO: r_lo <= bus.src_a;
                        default: ;
                     endcase
                  end
               end
               S_MUL: begin
                  {r_hi, r_lo} <= w_prod;
                  r_done       <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
               S_DIV: begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_LAST) r_state <= S_FIX;
               end
               S_FIX: begin
                  r_lo    <= w_q_fix;
                  r_hi    <= w_r_fix;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Operand and divider working registers carry no reset; the FSM gates their use.
   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_a      <= bus.src_a;
         r_b      <= bus.src_b;
         r_signed <= ~bus.op[0];
         r_neg_q  <= ~bus.op[0] & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
         r_neg_r  <= ~bus.op[0] & bus.src_a[DATA_W-1];
         r_divz   <= (bus.src_b == '0);
         r_rem    <= '0;
         r_quo    <= bus.op[0] ? bus.src_a : f_abs(bus.src_a);
         r_div    <= bus.op[0] ? bus.src_b : f_abs(bus.src_b);
      end else if (r_state == S_DIV) begin
         r_rem <= w_rem_nxt;
         r_quo <= w_quo_nxt;
      end
   end

   assign bus.isbusy = r_busy;
   assign bus.done   = r_done;
   assign bus.hi     = r_hi;
   assign bus.lo     = r_lo;
endmodule
